// File: rtl/pe_idx_loader_pkg.sv
// Shared PE parameters and helpers, plus the index-loader FSM state type.
package pe_idx_loader_pkg;

    localparam int IDX_W = 8;

    function automatic int bw(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_SW,
        SWITCH
    } loader_state_e;

endpackage

// File: rtl/pe_idx_loader_if.sv
// Valid/ready stream of packed index pairs feeding the index loader.
interface pe_idx_loader_if;
    import pe_idx_loader_pkg::*;

    logic [2*IDX_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/pe_idx_loader.sv
// Writer side of the PE index ping-pong buffer: streams index pairs into the
// shadow half, then pulses switch_idx_buf once the AGU is finished with the live half.
module pe_idx_loader
    import pe_idx_loader_pkg::*;
#(
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = bw(IDX_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [7:0]            load_cnt,
    output logic                  load_done,
    pe_idx_loader_if.slave        in_stream,
    output logic [2*IDX_W-1:0]    idx_wr_data,
    output logic [IDX_ADDR_W-1:0] idx_wr_addr,
    output logic                  idx_wr_en,
    input  logic                  agu_done,
    input  logic                  agu_start,
    output logic                  switch_idx_buf
);

    loader_state_e state;
    loader_state_e state_nxt;
    logic [7:0]    cnt_r;
    logic [7:0]    wr_cnt;
    logic          accept;
    logic          last_beat;
    logic          switch_ok;

    assign in_stream.in_ready = (state == LOAD) && (wr_cnt < cnt_r);
    assign accept             = in_stream.in_valid && in_stream.in_ready;
    assign last_beat          = (wr_cnt == cnt_r - 8'd1);

    // The last write must land before the halves swap, and an AGU start seen with
    // done means the AGU has just begun on the old half, so wait for its next done.
    assign switch_ok = agu_done && !agu_start && !idx_wr_en;

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (load_start) state_nxt = (load_cnt == 8'd0) ? WAIT_SW : LOAD;
            LOAD:    if (accept && last_beat) state_nxt = WAIT_SW;
            WAIT_SW: if (switch_ok) state_nxt = SWITCH;
            SWITCH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r          <= '0;
            wr_cnt         <= '0;
            idx_wr_en      <= 1'b0;
            idx_wr_addr    <= '0;
            idx_wr_data    <= '0;
            switch_idx_buf <= 1'b0;
            load_done      <= 1'b1;
        end else begin
            idx_wr_en      <= accept;
            switch_idx_buf <= (state == WAIT_SW) && switch_ok;
            load_done      <= (state_nxt == IDLE);
            if (state == IDLE && load_start) begin
                cnt_r  <= load_cnt;
                wr_cnt <= '0;
            end
            if (accept) begin
                idx_wr_data <= in_stream.in_data;
                idx_wr_addr <= IDX_ADDR_W'(wr_cnt);
                wr_cnt      <= wr_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pe_idx_loader.sv
// Self-checking bench for pe_idx_loader: directed scenarios plus randomized loads
// compared against an event-level model of writes and switch timing.
module tb_pe_idx_loader;
    import pe_idx_loader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 2 * IDX_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [7:0]    load_cnt;
    logic          load_done;
    logic [DW-1:0] idx_wr_data;
    logic [AW-1:0] idx_wr_addr;
    logic          idx_wr_en;
    logic          agu_done;
    logic          agu_start;
    logic          switch_idx_buf;

    pe_idx_loader_if bus ();

    pe_idx_loader #(.IDX_DEPTH(256), .IDX_ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .load_cnt       (load_cnt),
        .load_done      (load_done),
        .in_stream      (bus),
        .idx_wr_data    (idx_wr_data),
        .idx_wr_addr    (idx_wr_addr),
        .idx_wr_en      (idx_wr_en),
        .agu_done       (agu_done),
        .agu_start      (agu_start),
        .switch_idx_buf (switch_idx_buf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_q[$];
    int            acc_cyc_q[$];
    int            sw_q[$];
    int            ld_rise_q[$];
    int            ld_fall_q[$];
    logic [DW-1:0] sent_q[$];
    logic          ld_prev = 1'b1;

    // Event log of what the DUT does, sampled mid-cycle.
    always @(negedge clk) begin
        if (idx_wr_en === 1'b1) wr_q.push_back('{cyc, idx_wr_addr, idx_wr_data});
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_cyc_q.push_back(cyc);
        if (switch_idx_buf === 1'b1) sw_q.push_back(cyc);
        if (load_done === 1'b1 && ld_prev === 1'b0) ld_rise_q.push_back(cyc);
        if (load_done === 1'b0 && ld_prev === 1'b1) ld_fall_q.push_back(cyc);
        ld_prev = load_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        acc_cyc_q.delete();
        sw_q.delete();
        ld_rise_q.delete();
        ld_fall_q.delete();
        sent_q.delete();
    endtask

    task automatic start_load(input logic [7:0] n);
        load_cnt   = n;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_cnt   = 8'($urandom);
    endtask

    // Source side of the stream: offers beats at the given density until n are taken.
    task automatic send_beats(input int n, input int density, output int last_acc);
        int acc;
        int budget;
        acc      = 0;
        budget   = 40 * n + 20;
        last_acc = -1;
        while (acc < n && budget > 0) begin
            bus.in_valid = ($urandom_range(99) < density);
            bus.in_data  = DW'($urandom);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sent_q.push_back(bus.in_data);
                last_acc = cyc;
                acc++;
            end
            tick();
            budget--;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (acc != n) $display("FAIL send_beats: accepted %0d beats, required %0d", acc, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        load_start = 1'b0;
        load_cnt   = 8'd0;
        agu_done   = 1'b0;
        agu_start  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({load_done, bus.in_ready, idx_wr_en, switch_idx_buf} !== 4'b1000)
            $display("FAIL reset_flags: done/ready/wr_en/switch = %b, required 1000",
                     {load_done, bus.in_ready, idx_wr_en, switch_idx_buf});
        else n_pass++;
        n_checks++;
        if (idx_wr_addr !== '0 || idx_wr_data !== '0)
            $display("FAIL reset_bus: addr=%h data=%h, required 0/0", idx_wr_addr, idx_wr_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_basic();
        int st;
        int last_acc;
        int bad;
        clear_logs();
        agu_done = 1'b1;
        st = cyc;
        start_load(8'd4);
        send_beats(4, 100, last_acc);
        repeat (6) tick();
        bad = (wr_q.size() != 4) ? 1 : 0;
        foreach (wr_q[i])
            if (i < sent_q.size() && i < acc_cyc_q.size() &&
                (wr_q[i].addr !== AW'(i) || wr_q[i].data !== sent_q[i] || wr_q[i].cyc != acc_cyc_q[i] + 1))
                bad++;
        n_checks++;
        if (bad != 0) $display("FAIL basic_writes: %0d bad, got %0d writes, required 4", bad, wr_q.size());
        else n_pass++;
        n_checks++;
        if (sw_q.size() != 1 || sw_q[0] != last_acc + 3)
            $display("FAIL basic_switch: %0d pulses first at %0d, required 1 at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1, last_acc + 3);
        else n_pass++;
        n_checks++;
        if (ld_fall_q.size() != 1 || ld_fall_q[0] != st + 1 || ld_rise_q.size() != 1 || ld_rise_q[0] != last_acc + 4)
            $display("FAIL basic_load_done: falls=%0d rises=%0d rise_at=%0d, required fall at %0d rise at %0d",
                     ld_fall_q.size(), ld_rise_q.size(), (ld_rise_q.size() > 0) ? ld_rise_q[0] : -1,
                     st + 1, last_acc + 4);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [4:0] pat;
        int bad;
        int held_bad;
        clear_logs();
        agu_done = 1'b1;
        held_bad = 0;
        pat      = 5'b10101;
        start_load(8'd3);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = pat[c];
            bus.in_data  = DW'($urandom);
            @(negedge clk);
            if ((c == 2 || c == 4) && (idx_wr_en !== 1'b0 || idx_wr_addr !== AW'(c / 2 - 1))) held_bad++;
            if (bus.in_valid && bus.in_ready) sent_q.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_drop: in_ready=%b, required 0", bus.in_ready);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (held_bad != 0) $display("FAIL stall_addr_hold: %0d stall cycles with wrong addr/wr_en", held_bad);
        else n_pass++;
        repeat (6) tick();
        bad = (wr_q.size() != 3 || sent_q.size() != 3) ? 1 : 0;
        foreach (wr_q[i])
            if (i < sent_q.size() && (wr_q[i].addr !== AW'(i) || wr_q[i].data !== sent_q[i])) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL stall_writes: %0d bad, got %0d writes, required 3", bad, wr_q.size());
        else n_pass++;
    endtask

    task automatic test_agu_wait();
        int last_acc;
        int rise;
        int early;
        clear_logs();
        agu_done = 1'b0;
        early    = 0;
        start_load(8'd2);
        send_beats(2, 100, last_acc);
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (switch_idx_buf !== 1'b0 || load_done !== 1'b0) early++;
            tick();
        end
        agu_done = 1'b1;
        @(negedge clk);
        rise = cyc;
        repeat (4) tick();
        n_checks++;
        if (early != 0) $display("FAIL agu_wait_hold: %0d cycles with switch or load_done while agu busy", early);
        else n_pass++;
        n_checks++;
        if (sw_q.size() != 1 || sw_q[0] != rise + 1 || ld_rise_q.size() != 1 || ld_rise_q[0] != rise + 2)
            $display("FAIL agu_wait_switch: %0d pulses at %0d, load_done rise %0d, required pulse %0d rise %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1,
                     (ld_rise_q.size() > 0) ? ld_rise_q[0] : -1, rise + 1, rise + 2);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 2) $display("FAIL agu_wait_writes: got %0d writes, required 2", wr_q.size());
        else n_pass++;
    endtask

    task automatic test_agu_coincident();
        int last_acc;
        int rise;
        clear_logs();
        agu_done = 1'b0;
        start_load(8'd1);
        send_beats(1, 100, last_acc);
        repeat (3) tick();
        agu_start = 1'b1;
        agu_done  = 1'b1;
        tick();
        agu_start = 1'b0;
        agu_done  = 1'b0;
        repeat (5) tick();
        agu_done = 1'b1;
        @(negedge clk);
        rise = cyc;
        repeat (4) tick();
        n_checks++;
        if (sw_q.size() != 1 || sw_q[0] != rise + 1)
            $display("FAIL coincident_switch: %0d pulses first at %0d, required 1 at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1, rise + 1);
        else n_pass++;
    endtask

    task automatic test_zero_cnt();
        int st;
        clear_logs();
        agu_done = 1'b1;
        st = cyc;
        start_load(8'd0);
        tick();
        load_cnt   = 8'd5;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (wr_q.size() != 0) $display("FAIL zero_writes: got %0d writes, required 0", wr_q.size());
        else n_pass++;
        n_checks++;
        if (sw_q.size() != 1 || sw_q[0] != st + 2)
            $display("FAIL zero_switch: %0d pulses first at %0d, required 1 at %0d",
                     sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1, st + 2);
        else n_pass++;
        n_checks++;
        if (load_done !== 1'b1 || ld_fall_q.size() != 1)
            $display("FAIL zero_switch_cycle_start: load_done=%b falls=%0d, required 1 and 1",
                     load_done, ld_fall_q.size());
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        int last_acc;
        int bad;
        clear_logs();
        agu_done = 1'b1;
        start_load(8'd9);
        send_beats(4, 100, last_acc);
        load_cnt   = 8'd3;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_beats(5, 70, last_acc);
        repeat (6) tick();
        bad = (wr_q.size() != 9) ? 1 : 0;
        foreach (wr_q[i])
            if (i < sent_q.size() && (wr_q[i].addr !== AW'(i) || wr_q[i].data !== sent_q[i])) bad++;
        n_checks++;
        if (bad != 0 || sw_q.size() != 1)
            $display("FAIL ignored_start: %0d bad, %0d writes, %0d pulses, required 9 writes 1 pulse",
                     bad, wr_q.size(), sw_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int last_acc;
        clear_logs();
        agu_done = 1'b1;
        start_load(8'd6);
        send_beats(3, 100, last_acc);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({load_done, bus.in_ready, idx_wr_en, switch_idx_buf} !== 4'b1000 ||
            idx_wr_addr !== '0 || idx_wr_data !== '0)
            $display("FAIL midload_reset: flags=%b addr=%h data=%h, required 1000/0/0",
                     {load_done, bus.in_ready, idx_wr_en, switch_idx_buf}, idx_wr_addr, idx_wr_data);
        else n_pass++;
        repeat (15) tick();
        n_checks++;
        if (sw_q.size() != 0 || wr_q.size() != 3)
            $display("FAIL midload_abandon: %0d pulses %0d writes, required 0 pulses 3 writes",
                     sw_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int n;
        int last_acc;
        int exp_sw;
        int guard;
        int bad;
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            agu_done  = 1'b0;
            agu_start = 1'b0;
            n = $urandom_range(24, 1);
            start_load(8'(n));
            send_beats(n, $urandom_range(100, 30), last_acc);
            exp_sw = -1;
            guard  = 0;
            while ((exp_sw < 0 || cyc <= exp_sw + 1) && guard < 200) begin
                agu_done  = ($urandom_range(99) < 35);
                agu_start = ($urandom_range(99) < 30);
                @(negedge clk);
                // Switch follows the first clean done once the last write has landed.
                if (exp_sw < 0 && cyc >= last_acc + 2 && agu_done && !agu_start) exp_sw = cyc + 1;
                tick();
                guard++;
            end
            agu_done  = 1'b0;
            agu_start = 1'b0;
            tick();
            bad = (wr_q.size() != n) ? 1 : 0;
            foreach (wr_q[i])
                if (i < sent_q.size() && (wr_q[i].addr !== AW'(i) || wr_q[i].data !== sent_q[i])) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL random_writes[%0d]: %0d bad, %0d writes, required %0d", k, bad, wr_q.size(), n);
            else n_pass++;
            n_checks++;
            if (sw_q.size() != 1 || sw_q[0] != exp_sw)
                $display("FAIL random_switch[%0d]: %0d pulses first at %0d, required 1 at %0d",
                         k, sw_q.size(), (sw_q.size() > 0) ? sw_q[0] : -1, exp_sw);
            else n_pass++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_agu_wait();
        test_agu_coincident();
        test_zero_cnt();
        test_ignored_start();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
